// File: rtl/dma_pkg.sv
// Shared types and constants for the single-channel DMA copy engine.
package dma_pkg;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  // FSM encoding kept as plain constants for compatibility with older tools
  typedef logic [1:0] state_e;
  localparam state_e IDLE   = 2'd0;
  localparam state_e RUN    = 2'd1;
  localparam state_e DRAIN  = 2'd2;
  localparam state_e FINISH = 2'd3;

  typedef logic mode_e;
  localparam mode_e MODE_COPY = 1'b0;
  localparam mode_e MODE_FILL = 1'b1;

  typedef logic [1:0] status_e;
  localparam status_e ST_OK      = 2'd0;
  localparam status_e ST_ABORTED = 2'd1;
  localparam status_e ST_LEN_ERR = 2'd2;

endpackage

// File: rtl/dma_skid_fifo.sv
// Two-entry shifting skid FIFO; entry 0 is always the head so the head is a flop.
module dma_skid_fifo
  import dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [SKID_CNT_W-1:0] count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] data0_q, data1_q;
  logic                  vld0_q, vld1_q;

  // Storage update; flush wins over push and pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data0_q <= '0;
      data1_q <= '0;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
    end else if (flush) begin
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!vld0_q) begin
            data0_q <= push_data;
            vld0_q  <= 1'b1;
          end else begin
            data1_q <= push_data;
            vld1_q  <= 1'b1;
          end
        end
        2'b01: begin
          data0_q <= data1_q;
          vld0_q  <= vld1_q;
          vld1_q  <= 1'b0;
        end
        2'b11: begin
          if (vld1_q) begin
            data0_q <= data1_q;
            data1_q <= push_data;
          end else begin
            data0_q <= push_data;
            vld0_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = SKID_CNT_W'(vld0_q) + SKID_CNT_W'(vld1_q);
  assign head  = data0_q;

endmodule

// File: rtl/dma_copy_engine.sv
// Single-channel DMA: copies/fills words from a 1-cycle-latency source into a
// ready/valid destination port through a 2-entry skid buffer.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned ADDR_WIDTH = 8,
  localparam int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            status,
  output logic [LEN_WIDTH-1:0]  words_done,
  output logic                  src_rd_en,
  output logic [ADDR_WIDTH-1:0] src_rd_addr,
  input  logic [DATA_WIDTH-1:0] src_rd_data,
  output logic                  dst_wr_en,
  output logic [ADDR_WIDTH-1:0] dst_wr_addr,
  output logic [DATA_WIDTH-1:0] dst_wr_data,
  input  logic                  dst_wr_ready
);

  state_e                state_q, state_d;
  mode_e                 mode_q;
  status_e               status_q;
  logic [LEN_WIDTH-1:0]  len_q, rd_cnt_q, words_done_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
  logic                  rd_vld_q, busy_q, done_q;

  logic [SKID_CNT_W-1:0] fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [2:0]            occ_c;
  logic                  pop_c, active_c, abort_c, accept_c, len_err_c, issue_c;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, read issue and credit decisions
  always_comb begin
    state_d   = state_q;
    pop_c     = dst_wr_en && dst_wr_ready;
    active_c  = (state_q == RUN) || (state_q == DRAIN);
    abort_c   = active_c && abort;
    accept_c  = (state_q == IDLE) && start && (length != '0);
    len_err_c = (state_q == IDLE) && start && (length == '0);
    // Words that will sit in the FIFO at the end of this cycle
    occ_c     = 3'(fifo_count) + 3'(rd_vld_q) - 3'(pop_c);
    issue_c   = (state_q == RUN) && !abort && (rd_cnt_q < len_q) && (occ_c < 3'd2);
    case (state_q)
      IDLE: begin
        if (accept_c)       state_d = RUN;
        else if (len_err_c) state_d = FINISH;
      end
      RUN: begin
        if (abort)                                             state_d = FINISH;
        else if (issue_c && (rd_cnt_q + LEN_WIDTH'(1) == len_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort)                                                 state_d = FINISH;
        else if ((words_done_q + LEN_WIDTH'(pop_c)) == len_q)     state_d = FINISH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transfer registers, counters and status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q       <= MODE_COPY;
      status_q     <= ST_OK;
      len_q        <= '0;
      rd_cnt_q     <= '0;
      words_done_q <= '0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      rd_vld_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      busy_q   <= (state_d == RUN) || (state_d == DRAIN);
      done_q   <= (state_d == FINISH);
      rd_vld_q <= issue_c;
      if (accept_c) begin
        mode_q       <= mode_e'(mode);
        len_q        <= length;
        rd_addr_q    <= src_addr;
        wr_addr_q    <= dst_addr;
        rd_cnt_q     <= '0;
        words_done_q <= '0;
        status_q     <= ST_OK;
      end else begin
        if (issue_c) begin
          rd_cnt_q <= rd_cnt_q + LEN_WIDTH'(1);
          if (mode_q == MODE_COPY) rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
        end
        if (pop_c) begin
          words_done_q <= words_done_q + LEN_WIDTH'(1);
          wr_addr_q    <= wr_addr_q + ADDR_WIDTH'(1);
        end
        if (len_err_c) begin
          status_q     <= ST_LEN_ERR;
          words_done_q <= '0;
        end else if (abort_c) begin
          status_q <= ST_ABORTED;
        end
      end
    end
  end

  dma_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_vld_q),
    .push_data (src_rd_data),
    .pop       (pop_c),
    .flush     (abort_c),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign status      = status_q;
  assign words_done  = words_done_q;
  assign src_rd_en   = issue_c;
  assign src_rd_addr = rd_addr_q;
  assign dst_wr_en   = (fifo_count != '0);
  assign dst_wr_addr = wr_addr_q;
  assign dst_wr_data = fifo_head;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine with a ROM model and a write log.
module tb_dma_copy_engine;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned LW = AW + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] length = '0;
  logic          busy, done;
  logic [1:0]    status;
  logic [LW-1:0] words_done;
  logic          src_rd_en;
  logic [AW-1:0] src_rd_addr;
  logic [DW-1:0] src_rd_data;
  logic          dst_wr_en;
  logic [AW-1:0] dst_wr_addr;
  logic [DW-1:0] dst_wr_data;
  logic          dst_wr_ready = 1'b1;

  logic [DW-1:0] rom [256];
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wa_log[$];
  logic [DW-1:0] wd_log[$];

  int checks = 0, errors = 0;
  int cyc = 0, base = 0, rel;
  int first_rd = -1, first_wr = -1, last_wr = -1, done_cyc = -1, done_cnt = 0;
  int stall_lo = 1000, stall_hi = 0, stall_bad = 0;
  logic          stalled_prev = 1'b0;
  logic [AW-1:0] prev_a;
  logic [DW-1:0] prev_d;

  dma_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .length       (length),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .status       (status),
    .words_done   (words_done),
    .src_rd_en    (src_rd_en),
    .src_rd_addr  (src_rd_addr),
    .src_rd_data  (src_rd_data),
    .dst_wr_en    (dst_wr_en),
    .dst_wr_addr  (dst_wr_addr),
    .dst_wr_data  (dst_wr_data),
    .dst_wr_ready (dst_wr_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Synchronous-read source memory
  always @(posedge clk) if (src_rd_en) src_rd_data <= rom[src_rd_addr];

  // Destination backpressure window, in cycles relative to accept
  always @(posedge clk) begin
    #1;
    dst_wr_ready = !(((cyc - base) >= stall_lo) && ((cyc - base) <= stall_hi));
  end

  // Transaction monitor
  always @(negedge clk) begin
    rel = cyc - base;
    if (src_rd_en) begin
      rd_log.push_back(src_rd_addr);
      if (first_rd < 0) first_rd = rel;
    end
    if (dst_wr_en && dst_wr_ready) begin
      wa_log.push_back(dst_wr_addr);
      wd_log.push_back(dst_wr_data);
      if (first_wr < 0) first_wr = rel;
      last_wr = rel;
    end
    if (done) begin
      done_cnt++;
      done_cyc = rel;
    end
    if (stalled_prev && !(dst_wr_en && dst_wr_addr == prev_a && dst_wr_data == prev_d))
      stall_bad++;
    stalled_prev = dst_wr_en && !dst_wr_ready;
    prev_a = dst_wr_addr;
    prev_d = dst_wr_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                    input logic [LW-1:0] n);
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; length = n; start = 1'b1;
    base = cyc; first_rd = -1; first_wr = -1; last_wr = -1; done_cyc = -1; done_cnt = 0;
    rd_log.delete(); wa_log.delete(); wd_log.delete();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    #1;
    chk({tag, " done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic chk_writes(input string tag, input logic [AW-1:0] d0, input logic [DW-1:0] v0,
                            input logic fill, input int n);
    logic [AW-1:0] ea;
    logic [DW-1:0] ev;
    chk({tag, " wr_count"}, 32'(wa_log.size()), 32'(n));
    for (int i = 0; i < n && i < wa_log.size(); i++) begin
      ea = d0 + AW'(i);
      ev = fill ? v0 : v0 + DW'(i);
      chk({tag, " wr_addr"}, 32'(wa_log[i]), 32'(ea));
      chk({tag, " wr_data"}, 32'(wd_log[i]), 32'(ev));
    end
  endtask

  initial begin
    int saved;
    for (int i = 0; i < 256; i++) rom[i] = DW'(i);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst status", 32'(status), 32'd0);
    chk("rst words_done", 32'(words_done), 32'd0);
    chk("rst src_rd_en", 32'(src_rd_en), 32'd0);
    chk("rst dst_wr_en", 32'(dst_wr_en), 32'd0);
    chk("rst src_rd_addr", 32'(src_rd_addr), 32'd0);
    chk("rst dst_wr_addr", 32'(dst_wr_addr), 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // 1: COPY 4 words 0x10 -> 0x80
    go(1'b0, 8'h10, 8'h80, 9'd4);
    chk("t1 busy c1", 32'(busy), 32'd1);
    chk("t1 rd_en c1", 32'(src_rd_en), 32'd1);
    chk("t1 rd_addr c1", 32'(src_rd_addr), 32'h10);
    wait_done("t1", 40);
    chk("t1 first_rd", 32'(first_rd), 32'd1);
    chk("t1 first_wr", 32'(first_wr), 32'd3);
    chk("t1 last_wr", 32'(last_wr), 32'd6);
    chk("t1 done_cyc", 32'(done_cyc), 32'd7);
    chk("t1 busy at done", 32'(busy), 32'd0);
    chk("t1 status", 32'(status), 32'd0);
    chk("t1 words_done", 32'(words_done), 32'd4);
    chk_writes("t1", 8'h80, 8'h10, 1'b0, 4);
    repeat (2) @(negedge clk);
    #1;
    chk("t1 done_cnt", 32'(done_cnt), 32'd1);
    chk("t1 status held", 32'(status), 32'd0);

    // 2: FILL 3 words of ROM[5]
    rom[5] = 8'hA5;
    go(1'b1, 8'h05, 8'h00, 9'd3);
    wait_done("t2", 40);
    chk("t2 done_cyc", 32'(done_cyc), 32'd6);
    chk("t2 status", 32'(status), 32'd0);
    chk("t2 rd_count", 32'(rd_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < rd_log.size(); i++)
      chk("t2 rd_addr", 32'(rd_log[i]), 32'h05);
    chk_writes("t2", 8'h00, 8'hA5, 1'b1, 3);
    rom[5] = 8'h05;

    // 3: COPY 6 words with destination stalled in cycles 4..6
    stall_lo = 4; stall_hi = 6;
    go(1'b0, 8'h20, 8'h40, 9'd6);
    repeat (5) @(negedge clk);
    #1;
    chk("t3 stall ready", 32'(dst_wr_ready), 32'd0);
    chk("t3 stall wr_en", 32'(dst_wr_en), 32'd1);
    chk("t3 stall wr_addr", 32'(dst_wr_addr), 32'h41);
    chk("t3 stall wr_data", 32'(dst_wr_data), 32'h21);
    wait_done("t3", 60);
    stall_lo = 1000; stall_hi = 0;
    chk("t3 last_wr", 32'(last_wr), 32'd11);
    chk("t3 done_cyc", 32'(done_cyc), 32'd12);
    chk("t3 status", 32'(status), 32'd0);
    chk("t3 words_done", 32'(words_done), 32'd6);
    chk("t3 stall_stable", 32'(stall_bad), 32'd0);
    chk_writes("t3", 8'h40, 8'h20, 1'b0, 6);

    // 4: zero length, then a normal 2-word copy
    go(1'b0, 8'h00, 8'h90, 9'd0);
    wait_done("t4a", 10);
    chk("t4a done_cyc", 32'(done_cyc), 32'd1);
    chk("t4a status", 32'(status), 32'd2);
    chk("t4a busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("t4a rd_count", 32'(rd_log.size()), 32'd0);
    chk("t4a wr_count", 32'(wa_log.size()), 32'd0);
    chk("t4a done_cnt", 32'(done_cnt), 32'd1);
    go(1'b0, 8'h50, 8'h90, 9'd2);
    wait_done("t4b", 30);
    chk("t4b done_cyc", 32'(done_cyc), 32'd5);
    chk("t4b status", 32'(status), 32'd0);
    chk_writes("t4b", 8'h90, 8'h50, 1'b0, 2);

    // 5: abort during a 10-word copy
    go(1'b0, 8'h30, 8'h60, 9'd10);
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    wait_done("t5", 20);
    chk("t5 done_cyc", 32'(done_cyc), 32'd6);
    chk("t5 status", 32'(status), 32'd1);
    chk("t5 words_done", 32'(words_done), 32'd3);
    chk("t5 last_wr", 32'(last_wr), 32'd5);
    repeat (5) @(negedge clk);
    #1;
    chk("t5 done_cnt", 32'(done_cnt), 32'd1);
    chk("t5 status held", 32'(status), 32'd1);
    chk_writes("t5", 8'h60, 8'h30, 1'b0, 3);

    // 6: address wrap, then reset in the middle of a transfer
    go(1'b0, 8'hFE, 8'hFF, 9'd3);
    wait_done("t6", 30);
    chk("t6 status", 32'(status), 32'd0);
    chk("t6 rd_count", 32'(rd_log.size()), 32'd3);
    if (rd_log.size() == 3) begin
      chk("t6 rd0", 32'(rd_log[0]), 32'hFE);
      chk("t6 rd1", 32'(rd_log[1]), 32'hFF);
      chk("t6 rd2", 32'(rd_log[2]), 32'h00);
    end
    chk_writes("t6", 8'hFF, 8'hFE, 1'b0, 3);

    go(1'b0, 8'h00, 8'h10, 9'd8);
    repeat (3) @(posedge clk);
    #1;
    chk("t6r wr_en before", 32'(dst_wr_en), 32'd1);
    chk("t6r busy before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6r busy", 32'(busy), 32'd0);
    chk("t6r done", 32'(done), 32'd0);
    chk("t6r src_rd_en", 32'(src_rd_en), 32'd0);
    chk("t6r dst_wr_en", 32'(dst_wr_en), 32'd0);
    chk("t6r status", 32'(status), 32'd0);
    chk("t6r words_done", 32'(words_done), 32'd0);
    chk("t6r src_rd_addr", 32'(src_rd_addr), 32'd0);
    chk("t6r dst_wr_addr", 32'(dst_wr_addr), 32'd0);
    saved = wa_log.size();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("t6r no writes", 32'(wa_log.size()), 32'(saved));
    chk("t6r no done", 32'(done_cnt), 32'd0);
    go(1'b0, 8'h70, 8'h20, 9'd2);
    wait_done("t6p", 30);
    chk("t6p done_cyc", 32'(done_cyc), 32'd5);
    chk("t6p status", 32'(status), 32'd0);
    chk_writes("t6p", 8'h20, 8'h70, 1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
